// File: rtl/proc_test_pkg.sv
// proc_test_pkg: shared types and constants for the processor test sequencer.
package proc_test_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RST,
        RUN,
        SCAN_SETUP,
        SCAN_OUT,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_out_reg.sv
// scan_out_reg: valid/ready holding register for the register scan stream.
// A capture loads index and data and raises valid; the beat is held unchanged
// until the host accepts it, and clear drops everything immediately.
module scan_out_reg
    import proc_test_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 capture,
    input  logic [REG_IDX_W-1:0] cap_idx,
    input  logic [31:0]          cap_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [31:0]          out_data
);

    // Hold the beat until valid&&ready, then zero it so idle outputs stay low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_idx   <= cap_idx;
            out_data  <= cap_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end
    end

endmodule

// File: rtl/regfile_scan_ctrl.sv
// regfile_scan_ctrl: resets the processor, runs it for a programmed number of
// cycles, freezes it, then takes over regfile read port A and streams every
// register out over a valid/ready interface.
module regfile_scan_ctrl
    import proc_test_pkg::*;
#(
    parameter int CYC_W        = 10,
    parameter int RESET_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CYC_W-1:0]     num_cycles,
    input  logic [REG_IDX_W-1:0] rs1_cpu,
    input  logic [31:0]          regA,
    input  logic                 out_ready,
    output logic                 cpu_reset,
    output logic                 cpu_run,
    output logic [REG_IDX_W-1:0] rs1_out,
    output logic                 test_mode,
    output logic                 out_valid,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [31:0]          out_data,
    output logic [CYC_W-1:0]     cycle_count,
    output logic                 busy,
    output logic                 done
);

    localparam int                   RST_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_W-1:0]     RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    scan_state_t          state, state_next;
    logic [CYC_W-1:0]     num_lat, num_lat_next;
    logic [CYC_W-1:0]     count_next;
    logic [RST_W-1:0]     rst_cnt, rst_cnt_next;
    logic [REG_IDX_W-1:0] scan_idx, scan_idx_next;
    logic                 capture;
    logic                 handshake;

    assign handshake = out_valid && out_ready;

    // While scanning, the regfile read-A select belongs to the sequencer.
    assign rs1_out = test_mode ? scan_idx : rs1_cpu;

    // Next-state and counter updates; abort overrides everything, including start.
    always_comb begin
        state_next    = state;
        num_lat_next  = num_lat;
        count_next    = cycle_count;
        rst_cnt_next  = rst_cnt;
        scan_idx_next = scan_idx;
        capture       = 1'b0;
        if (abort) begin
            state_next    = IDLE;
            count_next    = '0;
            rst_cnt_next  = '0;
            scan_idx_next = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat_next  = num_cycles;
                        count_next    = '0;
                        rst_cnt_next  = '0;
                        scan_idx_next = '0;
                        state_next    = CPU_RST;
                    end
                end
                CPU_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        scan_idx_next = '0;
                        state_next    = (num_lat != '0) ? RUN : SCAN_SETUP;
                    end else begin
                        rst_cnt_next = rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    count_next = cycle_count + 1'b1;
                    if (count_next == num_lat) begin
                        scan_idx_next = '0;
                        state_next    = SCAN_SETUP;
                    end
                end
                SCAN_SETUP: begin
                    capture    = 1'b1;
                    state_next = SCAN_OUT;
                end
                SCAN_OUT: begin
                    if (handshake) begin
                        if (scan_idx == LAST_IDX) begin
                            state_next = DONE;
                        end else begin
                            scan_idx_next = scan_idx + 1'b1;
                            state_next    = SCAN_SETUP;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, counters and registered status outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            num_lat     <= '0;
            cycle_count <= '0;
            rst_cnt     <= '0;
            scan_idx    <= '0;
            cpu_reset   <= 1'b0;
            cpu_run     <= 1'b0;
            test_mode   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            num_lat     <= num_lat_next;
            cycle_count <= count_next;
            rst_cnt     <= rst_cnt_next;
            scan_idx    <= scan_idx_next;
            cpu_reset   <= (state_next == CPU_RST);
            cpu_run     <= (state_next == RUN);
            test_mode   <= (state_next == SCAN_SETUP) || (state_next == SCAN_OUT);
            busy        <= (state_next != IDLE) && (state_next != DONE);
            done        <= (state_next == DONE);
        end
    end

    scan_out_reg u_scan_out_reg (
        .clock     (clock),
        .reset     (reset),
        .clear     (abort),
        .capture   (capture),
        .cap_idx   (scan_idx),
        .cap_data  (regA),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// tb_regfile_scan_ctrl: table-driven and randomized runs of the test sequencer
// against a transaction-level model of run length, reset length and scan order.
module tb_regfile_scan_ctrl;

    localparam int CYC_W        = 10;
    localparam int RESET_CYCLES = 2;
    localparam int MAXT         = 2048;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [9:0]  num_cycles;
    logic [4:0]  rs1_cpu;
    logic [31:0] regA;
    logic        out_ready;
    logic        cpu_reset;
    logic        cpu_run;
    logic [4:0]  rs1_out;
    logic        test_mode;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic [9:0]  cycle_count;
    logic        busy;
    logic        done;

    logic [31:0] regs [0:31];
    bit          ready_pat [0:MAXT-1];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int n;
        int ready_mode;
        int data_mode;
        int poke_at;
        int exp_count;
        int exp_run;
    } run_vec_t;

    run_vec_t vecs [0:5];

    regfile_scan_ctrl #(.CYC_W(CYC_W), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_cycles  (num_cycles),
        .rs1_cpu     (rs1_cpu),
        .regA        (regA),
        .out_ready   (out_ready),
        .cpu_reset   (cpu_reset),
        .cpu_run     (cpu_run),
        .rs1_out     (rs1_out),
        .test_mode   (test_mode),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .cycle_count (cycle_count),
        .busy        (busy),
        .done        (done)
    );

    // Combinational regfile read port A.
    assign regA = regs[rs1_out];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete run from IDLE or DONE, observed cycle by cycle.
    task automatic apply_stimulus(input run_vec_t v);
        int tm, done_t, rst_seen, run_seen, busy_low, rs1_bad, k;
        logic       stalled;
        logic [4:0] hold_idx;
        logic [31:0] hold_data;
        for (int i = 0; i < 32; i++)
            regs[i] = (v.data_mode == 0) ? 32'(100 + i) : $urandom();
        for (int t = 0; t < MAXT; t++) begin
            if (v.ready_mode == 0)      ready_pat[t] = 1'b1;
            else if (v.ready_mode == 1) ready_pat[t] = ((t % 3) == 2);
            else                        ready_pat[t] = ($urandom_range(0, 1) == 1);
        end
        // Expected first DONE cycle: reset, run, then per register one setup
        // cycle plus output cycles up to and including the accepting one.
        tm = RESET_CYCLES + v.n;
        for (int r = 0; r < 32; r++) begin
            tm++;
            while (tm < MAXT - 1 && !ready_pat[tm]) tm++;
            tm++;
        end

        start      = 1'b1;
        num_cycles = 10'(v.n);
        step();
        start    = 1'b0;
        done_t   = -1;
        rst_seen = 0;
        run_seen = 0;
        busy_low = 0;
        rs1_bad  = 0;
        k        = 0;
        stalled  = 1'b0;
        hold_idx = '0;
        hold_data = '0;
        for (int t = 0; t < MAXT - 1; t++) begin
            out_ready = ready_pat[t];
            rs1_cpu   = 5'($urandom_range(0, 31));
            if (t == v.poke_at) begin
                start      = 1'b1;
                num_cycles = 10'(v.n + 7);
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                done_t = t;
                break;
            end
            if (cpu_reset) rst_seen++;
            if (cpu_run) run_seen++;
            if (!busy) busy_low++;
            if (!test_mode && rs1_out !== rs1_cpu) rs1_bad++;
            if (stalled)
                check_output("stall_hold", {26'd0, out_valid, out_idx, out_data},
                             {26'd0, 1'b1, hold_idx, hold_data});
            if (out_valid && out_ready) begin
                if (k < 32)
                    check_output("beat", {27'd0, out_idx, out_data}, {27'd0, k[4:0], regs[k]});
                k++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled   = 1'b1;
                hold_idx  = out_idx;
                hold_data = out_data;
            end else begin
                stalled = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check_output("done_cycle", 64'(done_t), 64'(tm));
        check_output("reset_cycles", 64'(rst_seen), 64'(RESET_CYCLES));
        check_output("run_cycles", 64'(run_seen), 64'(v.exp_run));
        check_output("beat_count", 64'(k), 64'd32);
        check_output("cycle_count", {54'd0, cycle_count}, 64'(v.exp_count));
        check_output("busy_during_run", 64'(busy_low), 64'd0);
        check_output("rs1_passthrough", 64'(rs1_bad), 64'd0);
        check_output("done_outputs",
                     {26'd0, cpu_reset, cpu_run, test_mode, out_valid, busy, out_idx, out_data},
                     64'd0);
    endtask

    initial begin
        run_vec_t rv;
        bit found;
        vecs[0] = '{n: 5,   ready_mode: 0, data_mode: 0, poke_at: -1, exp_count: 5,   exp_run: 5};
        vecs[1] = '{n: 0,   ready_mode: 0, data_mode: 1, poke_at: -1, exp_count: 0,   exp_run: 0};
        vecs[2] = '{n: 9,   ready_mode: 1, data_mode: 1, poke_at: -1, exp_count: 9,   exp_run: 9};
        vecs[3] = '{n: 12,  ready_mode: 0, data_mode: 1, poke_at: RESET_CYCLES + 3, exp_count: 12, exp_run: 12};
        vecs[4] = '{n: 40,  ready_mode: 2, data_mode: 1, poke_at: -1, exp_count: 40,  exp_run: 40};
        vecs[5] = '{n: 300, ready_mode: 1, data_mode: 1, poke_at: -1, exp_count: 300, exp_run: 300};

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_cycles = '0;
        rs1_cpu    = 5'h0A;
        out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(100 + i);
        #3;
        check_output("reset_state",
                     {11'd0, cpu_reset, cpu_run, test_mode, out_valid, busy, done, out_idx, out_data, cycle_count},
                     64'd0);
        check_output("reset_rs1", {59'd0, rs1_out}, 64'h0A);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step();

        for (int v = 0; v < 6; v++) apply_stimulus(vecs[v]);

        // Asynchronous reset in the middle of a run.
        start      = 1'b1;
        num_cycles = 10'd20;
        step();
        start = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (cycle_count == 10'd7) break;
            step();
        end
        check_output("reach_count7", {54'd0, cycle_count}, 64'd7);
        rs1_cpu = 5'h13;
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset",
                     {11'd0, cpu_reset, cpu_run, test_mode, out_valid, busy, done, out_idx, out_data, cycle_count},
                     64'd0);
        check_output("async_reset_rs1", {59'd0, rs1_out}, 64'h13);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();

        // Abort while a beat at index 12 is stalled.
        start      = 1'b1;
        num_cycles = 10'd2;
        step();
        start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            out_ready = 1'b1;
            #1;
            if (out_valid && out_idx == 5'd12) break;
            step();
        end
        check_output("reach_idx12", {58'd0, out_valid, out_idx}, {58'd0, 1'b1, 5'd12});
        out_ready = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        check_output("abort_outputs",
                     {58'd0, cpu_reset, cpu_run, test_mode, out_valid, busy, done}, 64'd0);
        step();
        check_output("abort_stays_idle", {62'd0, busy, done}, 64'd0);
        apply_stimulus(vecs[2]);

        // Start and abort together from IDLE: abort wins.
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        start      = 1'b1;
        abort      = 1'b1;
        num_cycles = 10'd4;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_output("start_abort_same", {61'd0, busy, cpu_reset, done}, 64'd0);
        step();
        check_output("start_abort_idle", {62'd0, busy, cpu_reset}, 64'd0);
        apply_stimulus(vecs[0]);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            found = 1'b1;
            rv.n          = $urandom_range(0, 40);
            rv.ready_mode = $urandom_range(0, 2);
            rv.data_mode  = 1;
            rv.poke_at    = found ? -1 : 0;
            rv.exp_count  = rv.n;
            rv.exp_run    = rv.n;
            apply_stimulus(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
